multicyc_ctrl_unit: RTL and testbench

MULTICYC_CTRL_UNIT -- requirements
Module: multicyc_ctrl_unit

---
 rtl/multicyc_ctrl_unit.sv | 162 ++++++++++++++++
 tb/tb_multicyc_ctrl_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicyc_ctrl_unit.sv
// rtl/multicyc_ctrl_unit.sv - multi-cycle MIPS-style control FSM with retired-instruction counter
module multicyc_ctrl_unit #(
    parameter int CNT_W = 32
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [5:0]       iOpCode,
    input  logic [5:0]       iFunct,
    input  logic             iMemReady,
    output logic             oPCWrite,
    output logic             oPCWriteCond,
    output logic             oBranchEq,
    output logic [1:0]       oPCSource,
    output logic             oIorD,
    output logic             oMemRead,
    output logic             oMemWrite,
    output logic             oIRWrite,
    output logic             oRegDst,
    output logic             oMemtoReg,
    output logic             oRegWrite,
    output logic             oLink,
    output logic             oALUSrcA,
    output logic [1:0]       oALUSrcB,
    output logic [1:0]       oALUOp,
    output logic             oIllegal,
    output logic [3:0]       oState,
    output logic [CNT_W-1:0] oInstCount
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_REXEC   = 4'd7,
        S_RWB     = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_JAL     = 4'd11,
        S_JR      = 4'd12, S_IEXEC  = 4'd13, S_IWB    = 4'd14, S_TRAP    = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_eq;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       link;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    state_t            state_q, state_d;
    ctrl_t             ctrl_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              retire;
    logic              fetch_ready;

    // Outputs are registered from the next state so they change with oState, not after it.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE:  c.alu_src_b = 2'b11;
            S_MEMADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            S_MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_REXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_RWB:     begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            S_BRANCH:  begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.branch_eq     = (op == 6'h04);
            end
            S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            S_JAL:     begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.reg_write = 1'b1;
                c.link      = 1'b1;
            end
            S_JR:      begin c.pc_write = 1'b1; c.pc_source = 2'b11; end
            S_IEXEC:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
            S_IWB:     c.reg_write = 1'b1;
            S_TRAP:    c.illegal = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   if (iMemReady) state_d = S_DECODE;
            S_DECODE:  begin
                case (iOpCode)
                    6'h00:                      state_d = (iFunct == 6'h08) ? S_JR : S_REXEC;
                    6'h23, 6'h2b:               state_d = S_MEMADDR;
                    6'h04, 6'h05:               state_d = S_BRANCH;
                    6'h02:                      state_d = S_JUMP;
                    6'h03:                      state_d = S_JAL;
                    6'h08, 6'h09, 6'h0a,
                    6'h0b, 6'h0c, 6'h0f:        state_d = S_IEXEC;
                    default:                    state_d = S_TRAP;
                endcase
            end
            S_MEMADDR: state_d = (iOpCode == 6'h23) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (iMemReady) state_d = S_MEMWB;
            S_MEMWR:   if (iMemReady) begin state_d = S_FETCH; retire = 1'b1; end
            S_REXEC:   state_d = S_RWB;
            S_IEXEC:   state_d = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:   state_d = state_q;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d, iOpCode);
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Instruction fetch completes in the same cycle memory signals ready.
    assign fetch_ready  = (state_q == S_FETCH) && iMemReady;

    assign oPCWrite     = ctrl_q.pc_write | fetch_ready;
    assign oIRWrite     = fetch_ready;
    assign oPCWriteCond = ctrl_q.pc_write_cond;
    assign oBranchEq    = ctrl_q.branch_eq;
    assign oPCSource    = ctrl_q.pc_source;
    assign oIorD        = ctrl_q.iord;
    assign oMemRead     = ctrl_q.mem_read;
    assign oMemWrite    = ctrl_q.mem_write;
    assign oRegDst      = ctrl_q.reg_dst;
    assign oMemtoReg    = ctrl_q.mem_to_reg;
    assign oRegWrite    = ctrl_q.reg_write;
    assign oLink        = ctrl_q.link;
    assign oALUSrcA     = ctrl_q.alu_src_a;
    assign oALUSrcB     = ctrl_q.alu_src_b;
    assign oALUOp       = ctrl_q.alu_op;
    assign oIllegal     = ctrl_q.illegal;
    assign oState       = state_q;
    assign oInstCount   = cnt_q;

endmodule

// File: tb/tb_multicyc_ctrl_unit.sv
// tb/tb_multicyc_ctrl_unit.sv - scoreboard bench for multicyc_ctrl_unit with an instruction-level model
module tb_multicyc_ctrl_unit;

    localparam int CNT_W = 3;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADDR = 3, ST_MEMRD = 4,
                   ST_MEMWB = 5, ST_MEMWR = 6, ST_REXEC = 7, ST_RWB = 8, ST_BRANCH = 9,
                   ST_JUMP = 10, ST_JAL = 11, ST_JR = 12, ST_IEXEC = 13, ST_IWB = 14, ST_TRAP = 15;

    logic             iClk = 1'b0;
    logic             iRst_n;
    logic [5:0]       iOpCode;
    logic [5:0]       iFunct;
    logic             iMemReady;
    logic             oPCWrite, oPCWriteCond, oBranchEq, oIorD, oMemRead, oMemWrite, oIRWrite;
    logic             oRegDst, oMemtoReg, oRegWrite, oLink, oALUSrcA, oIllegal;
    logic [1:0]       oPCSource, oALUSrcB, oALUOp;
    logic [3:0]       oState;
    logic [CNT_W-1:0] oInstCount;

    typedef struct packed {
        logic [3:0]       st;
        logic             pcw, pcwc, beq;
        logic [1:0]       pcsrc;
        logic             iord, mrd, mwr, irw, rdst, m2r, rw, link, sa;
        logic [1:0]       sb, aop;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    obs_t             sb_q[$];
    obs_t             mon_exp;
    int               errors = 0;
    int               checks = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    multicyc_ctrl_unit #(.CNT_W(CNT_W)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iOpCode(iOpCode), .iFunct(iFunct),
        .iMemReady(iMemReady), .oPCWrite(oPCWrite), .oPCWriteCond(oPCWriteCond),
        .oBranchEq(oBranchEq), .oPCSource(oPCSource), .oIorD(oIorD), .oMemRead(oMemRead),
        .oMemWrite(oMemWrite), .oIRWrite(oIRWrite), .oRegDst(oRegDst), .oMemtoReg(oMemtoReg),
        .oRegWrite(oRegWrite), .oLink(oLink), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB),
        .oALUOp(oALUOp), .oIllegal(oIllegal), .oState(oState), .oInstCount(oInstCount)
    );

    always #5 iClk = ~iClk;

    function automatic obs_t sample();
        obs_t o;
        o.st = oState; o.pcw = oPCWrite; o.pcwc = oPCWriteCond; o.beq = oBranchEq;
        o.pcsrc = oPCSource; o.iord = oIorD; o.mrd = oMemRead; o.mwr = oMemWrite;
        o.irw = oIRWrite; o.rdst = oRegDst; o.m2r = oMemtoReg; o.rw = oRegWrite;
        o.link = oLink; o.sa = oALUSrcA; o.sb = oALUSrcB; o.aop = oALUOp;
        o.ill = oIllegal; o.cnt = oInstCount;
        return o;
    endfunction

    // What each phase of an instruction should present, straight from the control table.
    function automatic obs_t expect_obs(input int st, input logic [5:0] op, input logic mr,
                                        input logic [CNT_W-1:0] cnt);
        obs_t o;
        o = '0;
        o.st  = 4'(st);
        o.cnt = cnt;
        case (st)
            ST_FETCH:   begin o.mrd = 1'b1; o.sb = 2'b01; o.irw = mr; o.pcw = mr; end
            ST_DECODE:  o.sb = 2'b11;
            ST_MEMADDR: begin o.sa = 1'b1; o.sb = 2'b10; end
            ST_MEMRD:   begin o.mrd = 1'b1; o.iord = 1'b1; end
            ST_MEMWB:   begin o.m2r = 1'b1; o.rw = 1'b1; end
            ST_MEMWR:   begin o.mwr = 1'b1; o.iord = 1'b1; end
            ST_REXEC:   begin o.sa = 1'b1; o.aop = 2'b10; end
            ST_RWB:     begin o.rdst = 1'b1; o.rw = 1'b1; end
            ST_BRANCH:  begin
                o.sa = 1'b1; o.aop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 2'b01;
                o.beq = (op == 6'h04);
            end
            ST_JUMP:    begin o.pcw = 1'b1; o.pcsrc = 2'b10; end
            ST_JAL:     begin o.pcw = 1'b1; o.pcsrc = 2'b10; o.rw = 1'b1; o.link = 1'b1; end
            ST_JR:      begin o.pcw = 1'b1; o.pcsrc = 2'b11; end
            ST_IEXEC:   begin o.sa = 1'b1; o.sb = 2'b10; o.aop = 2'b11; end
            ST_IWB:     o.rw = 1'b1;
            ST_TRAP:    o.ill = 1'b1;
            default:    o = o;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h (state got %0d exp %0d, count got %0d exp %0d)",
                     name, $time, act, exp, act.st, exp.st, act.cnt, exp.cnt);
        end
    endtask

    always @(negedge iClk) begin
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            check("cycle", sample(), mon_exp);
        end
    end

    task automatic step(input int st, input logic mr);
        @(posedge iClk);
        #1;
        iMemReady = mr;
        sb_q.push_back(expect_obs(st, iOpCode, mr, model_cnt));
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic retire_step(input int st);
        step(st, rnd_bit());
        model_cnt = model_cnt + 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        iOpCode = op;
        iFunct  = fn;
        repeat (fw) step(ST_FETCH, 1'b0);
        step(ST_FETCH, 1'b1);
        step(ST_DECODE, rnd_bit());
        case (op)
            6'h00: if (fn == 6'h08) retire_step(ST_JR);
                   else begin step(ST_REXEC, rnd_bit()); retire_step(ST_RWB); end
            6'h23: begin
                step(ST_MEMADDR, rnd_bit());
                repeat (mw) step(ST_MEMRD, 1'b0);
                step(ST_MEMRD, 1'b1);
                retire_step(ST_MEMWB);
            end
            6'h2b: begin
                step(ST_MEMADDR, rnd_bit());
                repeat (mw) step(ST_MEMWR, 1'b0);
                step(ST_MEMWR, 1'b1);
                model_cnt = model_cnt + 1'b1;
            end
            6'h04, 6'h05: retire_step(ST_BRANCH);
            6'h02: retire_step(ST_JUMP);
            6'h03: retire_step(ST_JAL);
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: begin
                step(ST_IEXEC, rnd_bit());
                retire_step(ST_IWB);
            end
            default: repeat (6) step(ST_TRAP, rnd_bit());
        endcase
    endtask

    task automatic release_reset();
        @(posedge iClk);
        #1;
        iRst_n    = 1'b1;
        iMemReady = rnd_bit();
        model_cnt = '0;
        sb_q.push_back(expect_obs(ST_IDLE, iOpCode, iMemReady, model_cnt));
    endtask

    task automatic reset_now(input string name);
        @(posedge iClk);
        #2;
        iRst_n = 1'b0;
        #1;
        check(name, sample(), '0);
        repeat (2) @(posedge iClk);
        #1;
        check({name, "_hold"}, sample(), '0);
    endtask

    logic [5:0] legal_ops [13] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03,
                                   6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f};

    initial begin
        logic [5:0] op, fn;
        iRst_n = 1'b0; iMemReady = 1'b0; iOpCode = '0; iFunct = '0;
        repeat (3) @(posedge iClk);
        #1;
        check("reset", sample(), '0);

        release_reset();
        run_instr(6'h00, 6'h20, 0, 0);
        run_instr(6'h23, 6'h00, 0, 3);
        run_instr(6'h04, 6'h00, 0, 0);
        run_instr(6'h05, 6'h00, 1, 0);
        run_instr(6'h03, 6'h00, 0, 0);
        run_instr(6'h00, 6'h08, 0, 0);
        run_instr(6'h2b, 6'h00, 2, 2);

        for (int i = 0; i < 150; i++) begin
            op = legal_ops[$urandom_range(0, 12)];
            fn = 6'($urandom_range(0, 63));
            if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'h08;
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Store stalled by memory, then reset lands in the middle of the write.
        iOpCode = 6'h2b;
        step(ST_FETCH, 1'b1);
        step(ST_DECODE, 1'b0);
        step(ST_MEMADDR, 1'b0);
        repeat (3) step(ST_MEMWR, 1'b0);
        reset_now("reset_in_memwr");

        release_reset();
        run_instr(6'h09, 6'h00, 0, 0);
        run_instr(6'h02, 6'h00, 1, 0);
        run_instr(6'h3f, 6'h00, 0, 0);
        reset_now("reset_in_trap");

        release_reset();
        run_instr(6'h0f, 6'h00, 0, 0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge iClk);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        @(negedge iClk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
